rx_dmac: RTL and testbench

- RX-direction DMA master. Drains 128-bit AXI-Stream beats from the RX FIFO and writes them to DDR as fixed-length AXI4 INCR write bursts (AW/W/B channels).
- Tracks a pseudo-FIFO occupation of the DDR ring so it never overruns data the host has not yet consumed.
- Raises a tick per completed burst, which the host uses as its "data available" interrupt.

---
 rtl/rx_dmac.sv | 224 ++++++++++++++++++++++
 tb/tb_rx_dmac.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_dmac.sv
// RX DMA master: drains AXI-Stream beats into fixed-length AXI4 INCR write bursts on a DDR ring.
// Optional macro RX_DMAC_WRAP_EN wraps the write address back to the ring base at the ring end.
module rx_dmac #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 48,
  parameter int unsigned OVF_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                write_enable,
  output logic                write_busy,
  input  logic [ADDR_W-1:0]   write_base_address,
  input  logic [31:0]         write_burst_count,
  input  logic [8:0]          write_burst_len,
  input  logic [31:0]         write_ddr_size,
  input  logic [16:0]         write_access_size_bytes,
  input  logic                write_access_tick,
  output logic                write_burst_tick,
  output logic [31:0]         write_total_burst_count,
  output logic [31:0]         write_current_burst_address,
  output logic                write_overflow_ins,
  output logic [OVF_W-1:0]    write_overflow_count,
  input  logic [DATA_W-1:0]   s_axis_rx_tdata,
  input  logic                s_axis_rx_tvalid,
  output logic                s_axis_rx_tready,
  input  logic                rx_fifo_has_burst,
  input  logic                rx_fifo_full,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);

  localparam int unsigned AW1 = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_AW, S_W, S_B, S_VERIFY
  } state_e;

  state_e             state_q, state_d;
  logic [8:0]         idx_q, idx_d;
  logic [31:0]        occ_q, occ_d;
  logic               acc_tick_q;
  logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
  logic               awvalid_q, awvalid_d;
  logic [31:0]        cur_addr_q, cur_addr_d;
  logic [31:0]        run_cnt_q, run_cnt_d;
  logic [31:0]        total_q, total_d;
  logic               berr_q, berr_d;
  logic               tick_q, tick_d;
  logic               ovf_ins_q, ovf_ins_d;
  logic [OVF_W-1:0]   ovf_cnt_q, ovf_cnt_d;

  logic [12:0]        burst_bytes;
  logic               has_space;
  logic               acc_rise;
  logic               w_fire;
  logic               wlast_c;
  logic [ADDR_W-1:0]  next_addr;
  logic [32:0]        occ_sum;
  logic               unused_bresp0;

  assign burst_bytes   = {write_burst_len, 4'b0000};
  assign has_space     = (33'(occ_q) + 33'(burst_bytes)) <= 33'(write_ddr_size);
  assign acc_rise      = write_access_tick & ~acc_tick_q;
  assign wlast_c       = (idx_q == (write_burst_len - 9'd1));
  assign w_fire        = (state_q == S_W) && s_axis_rx_tvalid && m_axi_wready;
  assign unused_bresp0 = m_axi_bresp[0];

  // Address of the burst after the one just accepted on AW
`ifdef RX_DMAC_WRAP_EN
  logic [ADDR_W:0] addr_inc, ring_end;
  always_comb begin
    addr_inc  = AW1'(awaddr_q) + AW1'(burst_bytes);
    ring_end  = AW1'(write_base_address) + AW1'(write_ddr_size);
    next_addr = (addr_inc >= ring_end) ? write_base_address : ADDR_W'(addr_inc);
  end
`else
  always_comb begin
    next_addr = awaddr_q + ADDR_W'(burst_bytes);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (write_enable) state_d = S_CHECK;
      S_CHECK:  if (rx_fifo_has_burst && has_space) state_d = S_AW;
      S_AW:     if (m_axi_awready) state_d = S_W;
      S_W:      if (w_fire && wlast_c) state_d = S_B;
      S_B:      if (m_axi_bvalid) state_d = S_VERIFY;
      S_VERIFY: state_d = ((run_cnt_q < write_burst_count) && !berr_q && write_enable)
                          ? S_CHECK : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    idx_d      = idx_q;
    awaddr_d   = awaddr_q;
    awvalid_d  = awvalid_q;
    cur_addr_d = cur_addr_q;
    run_cnt_d  = run_cnt_q;
    total_d    = total_q;
    berr_d     = berr_q;
    tick_d     = 1'b0;
    ovf_ins_d  = 1'b0;
    ovf_cnt_d  = ovf_cnt_q;

    // Ring occupation: completed bursts fill it, host accesses drain it (floored at 0)
    occ_sum = 33'(occ_q) + (tick_q ? 33'(burst_bytes) : 33'd0);
    if (acc_rise) begin
      occ_sum = (occ_sum >= 33'(write_access_size_bytes))
                ? occ_sum - 33'(write_access_size_bytes) : 33'd0;
    end
    occ_d = 32'(occ_sum);

    unique case (state_q)
      S_IDLE: begin
        awaddr_d   = write_base_address;
        cur_addr_d = write_base_address[31:0];
        run_cnt_d  = 32'd0;
        if (!write_enable) begin
          total_d   = 32'd0;
          ovf_cnt_d = '0;
        end
      end
      S_CHECK: begin
        if (rx_fifo_has_burst && has_space) begin
          awvalid_d  = 1'b1;
          cur_addr_d = awaddr_q[31:0];
        end
        if (rx_fifo_full && (total_q != 32'd0)) begin
          ovf_ins_d = 1'b1;
          if (ovf_cnt_q != {OVF_W{1'b1}}) ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
        end
      end
      S_AW: begin
        if (m_axi_awready) begin
          awvalid_d = 1'b0;
          awaddr_d  = next_addr;
          idx_d     = 9'd0;
        end
      end
      S_W: begin
        if (w_fire) idx_d = idx_q + 9'd1;
      end
      S_B: begin
        if (m_axi_bvalid) begin
          berr_d = m_axi_bresp[1];
          if (!m_axi_bresp[1]) begin
            tick_d    = 1'b1;
            run_cnt_d = run_cnt_q + 32'd1;
            total_d   = total_q + 32'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= 9'd0;
      occ_q      <= 32'd0;
      acc_tick_q <= 1'b0;
      awaddr_q   <= write_base_address;
      awvalid_q  <= 1'b0;
      cur_addr_q <= 32'd0;
      run_cnt_q  <= 32'd0;
      total_q    <= 32'd0;
      berr_q     <= 1'b0;
      tick_q     <= 1'b0;
      ovf_ins_q  <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      idx_q      <= idx_d;
      occ_q      <= occ_d;
      acc_tick_q <= write_access_tick;
      awaddr_q   <= awaddr_d;
      awvalid_q  <= awvalid_d;
      cur_addr_q <= cur_addr_d;
      run_cnt_q  <= run_cnt_d;
      total_q    <= total_d;
      berr_q     <= berr_d;
      tick_q     <= tick_d;
      ovf_ins_q  <= ovf_ins_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign write_busy                  = (state_q != S_IDLE);
  assign write_burst_tick            = tick_q;
  assign write_total_burst_count     = total_q;
  assign write_current_burst_address = cur_addr_q;
  assign write_overflow_ins          = ovf_ins_q;
  assign write_overflow_count        = ovf_cnt_q;

  // W channel is a straight pass-through of the stream while a burst is open
  assign m_axi_awaddr     = awaddr_q;
  assign m_axi_awlen      = 8'(write_burst_len - 9'd1);
  assign m_axi_awvalid    = awvalid_q;
  assign m_axi_wdata      = s_axis_rx_tdata;
  assign m_axi_wstrb      = {(DATA_W/8){1'b1}};
  assign m_axi_wvalid     = (state_q == S_W) && s_axis_rx_tvalid;
  assign s_axis_rx_tready = (state_q == S_W) && m_axi_wready;
  assign m_axi_wlast      = (state_q == S_W) && wlast_c;
  assign m_axi_bready     = (state_q == S_B);

endmodule

// File: tb/tb_rx_dmac.sv
// Directed bench for rx_dmac: bursts, ring-full stall, backpressure, error response, overflow, enable drop.
module tb_rx_dmac;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADDR_W = 48;
  localparam int unsigned OVF_W  = 8;
  localparam logic [ADDR_W-1:0] BASE = 48'h0012_3456_7000;

  logic                clk, rst_n;
  logic                write_enable, write_busy;
  logic [ADDR_W-1:0]   write_base_address;
  logic [31:0]         write_burst_count, write_ddr_size;
  logic [8:0]          write_burst_len;
  logic [16:0]         write_access_size_bytes;
  logic                write_access_tick, write_burst_tick;
  logic [31:0]         write_total_burst_count, write_current_burst_address;
  logic                write_overflow_ins;
  logic [OVF_W-1:0]    write_overflow_count;
  logic [DATA_W-1:0]   s_axis_rx_tdata;
  logic                s_axis_rx_tvalid, s_axis_rx_tready;
  logic                rx_fifo_has_burst, rx_fifo_full;
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [7:0]          m_axi_awlen;
  logic                m_axi_awvalid, m_axi_awready;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]          m_axi_bresp;
  logic                m_axi_bvalid, m_axi_bready;

  rx_dmac #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OVF_W(OVF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .write_enable(write_enable), .write_busy(write_busy),
    .write_base_address(write_base_address), .write_burst_count(write_burst_count),
    .write_burst_len(write_burst_len), .write_ddr_size(write_ddr_size),
    .write_access_size_bytes(write_access_size_bytes), .write_access_tick(write_access_tick),
    .write_burst_tick(write_burst_tick), .write_total_burst_count(write_total_burst_count),
    .write_current_burst_address(write_current_burst_address),
    .write_overflow_ins(write_overflow_ins), .write_overflow_count(write_overflow_count),
    .s_axis_rx_tdata(s_axis_rx_tdata), .s_axis_rx_tvalid(s_axis_rx_tvalid),
    .s_axis_rx_tready(s_axis_rx_tready),
    .rx_fifo_has_burst(rx_fifo_has_burst), .rx_fifo_full(rx_fifo_full),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed traffic, sampled on the falling edge
  logic [ADDR_W-1:0] aw_q[$];
  logic [31:0]       data_q[$];
  logic              last_q[$];
  int                ticks, ovf_pulses;
  logic              fire;
  logic              bp_mode;

  initial begin
    ticks = 0; ovf_pulses = 0; fire = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_q.delete(); data_q.delete(); last_q.delete();
        ticks = 0; ovf_pulses = 0; fire = 1'b0;
      end else begin
        fire = s_axis_rx_tvalid && s_axis_rx_tready;
        if (m_axi_awvalid && m_axi_awready) aw_q.push_back(m_axi_awaddr);
        if (m_axi_wvalid && m_axi_wready) begin
          data_q.push_back(m_axi_wdata[31:0]);
          last_q.push_back(m_axi_wlast);
        end
        if (write_burst_tick) ticks++;
        if (write_overflow_ins) ovf_pulses++;
      end
    end
  end

  // Stream source: incrementing payload, optional wready toggling and tvalid gaps
  initial begin
    int src_cnt;
    int phase;
    src_cnt = 0; phase = 0;
    s_axis_rx_tdata = '0; s_axis_rx_tvalid = 1'b0; m_axi_wready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        src_cnt = 0; phase = 0;
      end else if (fire) begin
        src_cnt++;
      end
      phase++;
      s_axis_rx_tdata = DATA_W'(src_cnt);
      if (bp_mode) begin
        m_axi_wready = phase[0];
        if (!(s_axis_rx_tvalid && !fire)) s_axis_rx_tvalid = ((phase % 3) != 2);
      end else begin
        m_axi_wready     = 1'b1;
        s_axis_rx_tvalid = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // sel: 0 = burst ticks reach n, 1 = AW handshakes reach n, 2 = busy low
  task automatic wait_for(input int sel, input int n, input int budget, input string tag);
    int k;
    int v;
    k = 0;
    v = (sel == 0) ? ticks : (sel == 1) ? aw_q.size() : int'(!write_busy);
    while (v < n && k < budget) begin
      step(1);
      k++;
      v = (sel == 0) ? ticks : (sel == 1) ? aw_q.size() : int'(!write_busy);
    end
    check({tag, "_wait"}, 64'(v >= n), 64'd1);
  endtask

  task automatic check_beats(input string tag, input int n_beats, input int len);
    int errs;
    errs = 0;
    for (int i = 0; i < data_q.size(); i++) begin
      if (data_q[i] != 32'(i)) errs++;
      if (last_q[i] != ((i % len) == len - 1)) errs++;
    end
    check({tag, "_beats"}, 64'(data_q.size()), 64'(n_beats));
    check({tag, "_order_last"}, 64'(errs), 64'd0);
  endtask

  task automatic start_run(input logic [8:0] len, input int cnt, input int ddr);
    rst_n = 1'b0; write_enable = 1'b0; rx_fifo_has_burst = 1'b0; rx_fifo_full = 1'b0;
    write_access_tick = 1'b0; m_axi_bresp = 2'b00;
    write_burst_len = len; write_burst_count = 32'(cnt); write_ddr_size = 32'(ddr);
    step(3);
    rst_n = 1'b1;
    step(1);
    write_enable = 1'b1;
    rx_fifo_has_burst = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; write_enable = 1'b0; write_base_address = BASE;
    write_burst_count = 32'd0; write_burst_len = 9'd16; write_ddr_size = 32'd0;
    write_access_size_bytes = 17'd256; write_access_tick = 1'b0;
    rx_fifo_has_burst = 1'b0; rx_fifo_full = 1'b0;
    m_axi_awready = 1'b1; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b1; bp_mode = 1'b0;

    // Reset values, sampled while reset is still asserted
    step(3);
    check("rst_busy",    64'(write_busy), 64'd0);
    check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("rst_awaddr",  64'(m_axi_awaddr), 64'(BASE));
    check("rst_wstrb",   64'(m_axi_wstrb), 64'hFFFF);
    check("rst_total",   64'(write_total_burst_count), 64'd0);
    check("rst_curaddr", 64'(write_current_burst_address), 64'd0);
    check("rst_ovfcnt",  64'(write_overflow_count), 64'd0);
    check("rst_tready",  64'(s_axis_rx_tready), 64'd0);
    check("rst_bready",  64'(m_axi_bready), 64'd0);
    check("rst_tick",    64'(write_burst_tick), 64'd0);

    // Basic two-burst run
    start_run(9'd16, 2, 4096);
    check("t1_awlen", 64'(m_axi_awlen), 64'd15);
    wait_for(0, 2, 300, "t1_ticks");
    rx_fifo_has_burst = 1'b0;
    wait_for(2, 1, 50, "t1_idle");
    check("t1_aw_n",   64'(aw_q.size()), 64'd2);
    check("t1_aw0",    64'(aw_q[0]), 64'(BASE));
    check("t1_aw1",    64'(aw_q[1]), 64'(BASE + 48'd256));
    check("t1_total",  64'(write_total_burst_count), 64'd2);
    check("t1_curaddr", 64'(write_current_burst_address), 64'h3456_7100);
    check_beats("t1", 32, 16);

    // Ring full stall, released by one access tick held for three cycles
    start_run(9'd16, 4, 512);
    wait_for(0, 2, 300, "t2_ticks");
    step(30);
    check("t2_stall_aw",   64'(aw_q.size()), 64'd2);
    check("t2_stall_busy", 64'(write_busy), 64'd1);
    check("t2_stall_awv",  64'(m_axi_awvalid), 64'd0);
    write_access_tick = 1'b1;
    step(3);
    write_access_tick = 1'b0;
    wait_for(1, 3, 100, "t2_aw3");
`ifdef RX_DMAC_WRAP_EN
    check("t2_aw2_wrap", 64'(aw_q[2]), 64'(BASE));
`else
    check("t2_aw2_lin",  64'(aw_q[2]), 64'(BASE + 48'd512));
`endif
    wait_for(0, 3, 200, "t2_ticks3");
    step(30);
    check("t2_one_release", 64'(aw_q.size()), 64'd3);

    // Backpressure on W and gaps on the stream
    bp_mode = 1'b1;
    start_run(9'd16, 1, 4096);
    wait_for(0, 1, 400, "t3_ticks");
    rx_fifo_has_burst = 1'b0;
    step(2);
    check_beats("t3", 16, 16);
    check("t3_total", 64'(write_total_burst_count), 64'd1);
    bp_mode = 1'b0;

    // SLVERR on the first burst ends the run without a tick
    start_run(9'd16, 2, 4096);
    m_axi_bresp = 2'b10;
    wait_for(1, 1, 50, "t4_aw");
    rx_fifo_has_burst = 1'b0;
    wait_for(2, 1, 200, "t4_idle");
    check("t4_ticks", 64'(ticks), 64'd0);
    check("t4_total", 64'(write_total_burst_count), 64'd0);
    check("t4_beats", 64'(data_q.size()), 64'd16);
    m_axi_bresp = 2'b00;

    // Overflow: FIFO full for three cycles while stalled in CHECK
    start_run(9'd16, 4, 256);
    wait_for(0, 1, 300, "t5_ticks");
    step(5);
    rx_fifo_full = 1'b1;
    step(3);
    rx_fifo_full = 1'b0;
    step(3);
    check("t5_ovfcnt",  64'(write_overflow_count), 64'd3);
    check("t5_ovfins",  64'(ovf_pulses), 64'd3);
    check("t5_aw_n",    64'(aw_q.size()), 64'd1);

    // Enable dropped mid-burst: burst and response finish, then idle and clear
    start_run(9'd16, 4, 4096);
    wait_for(1, 1, 50, "t6_aw");
    write_enable = 1'b0;
    wait_for(2, 1, 200, "t6_idle");
    check("t6_ticks", 64'(ticks), 64'd1);
    check("t6_beats", 64'(data_q.size()), 64'd16);
    check("t6_aw_n",  64'(aw_q.size()), 64'd1);
    step(2);
    check("t6_total_clr", 64'(write_total_burst_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
